// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// ----------------
// Synchronous-read instruction memory behind a request/response fetch
// handshake. One fetch is outstanding at a time. A fetch is answered
// WAIT_CYCLES+1 cycles after it is accepted, and the response is held
// until it is consumed. A program-load write port can update the array
// in any state. Misaligned or out-of-range fetches return NOP_INST with
// rsp_fault set. The fault path has the same timing as a normal fetch.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   fetch request valid
//   req_pc     in   [31:0] byte address of the fetch
//   req_ready  out  request can be accepted this cycle (combinational)
//   rsp_valid  out  response valid
//   rsp_ready  in   consumer accepts the response
//   rsp_inst   out  [31:0] fetched instruction (NOP_INST on fault)
//   rsp_pc     out  [31:0] PC of the answered request
//   rsp_fault  out  misaligned / out-of-range fetch
//   flush      in   abort any in-flight fetch
//   load_en    in   program-load write enable
//   load_addr  in   [ADDR_W-1:0] word index to write
//   load_data  in   [31:0] word to write
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [31:0]       req_pc,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_inst,
  output logic [31:0]       rsp_pc,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  // The count loaded on entry to WAIT. It is never used when WAIT_CYCLES is 0.
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cap_pc_q, cap_pc_d;
  logic        cap_fault_q, cap_fault_d;
  logic [31:0] rsp_inst_q, rsp_inst_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        rsp_fault_q, rsp_fault_d;

  logic [31:0] mem [0:DEPTH-1];

  logic              accept;
  logic              req_fault;
  logic              enter_resp;
  logic [31:0]       src_pc;
  logic              src_fault;
  logic [ADDR_W-1:0] rd_idx;

  assign req_ready = (state_q == S_IDLE) && !load_en && !flush;
  assign accept    = req_valid && req_ready;
  // Upper address bits are only range-checked. They never index the array.
  assign req_fault = (req_pc[1:0] != 2'b00) || (req_pc[31:2] >= 30'(DEPTH));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_pc_d    = cap_pc_q;
    cap_fault_d = cap_fault_q;
    enter_resp  = 1'b0;
    src_pc      = cap_pc_q;
    src_fault   = cap_fault_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cap_pc_d    = req_pc;
          cap_fault_d = req_fault;
          if (WAIT_CYCLES == 0) begin
            // With no wait states, the array is read on the accept edge itself.
            state_d    = S_RESP;
            enter_resp = 1'b1;
            src_pc     = req_pc;
            src_fault  = req_fault;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // Flush wins over rsp_ready, but both simply return to IDLE.
        if (flush || rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_idx = src_pc[ADDR_W+1:2];

  // The response registers only change on the edge that enters RESP.
  // They hold their values while the response waits and after it is consumed.
  always_comb begin
    rsp_inst_d  = rsp_inst_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_fault_d = rsp_fault_q;
    if (enter_resp) begin
      rsp_inst_d  = src_fault ? NOP_INST : mem[rd_idx];
      rsp_pc_d    = src_pc;
      rsp_fault_d = src_fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      cap_pc_q    <= 32'd0;
      cap_fault_q <= 1'b0;
      rsp_inst_q  <= NOP_INST;
      rsp_pc_q    <= 32'd0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_pc_q    <= cap_pc_d;
      cap_fault_q <= cap_fault_d;
      rsp_inst_q  <= rsp_inst_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // The array has no reset. A read on the same edge as a write to the same
  // word sees the old contents because of nonblocking update ordering.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_inst  = rsp_inst_q;
  assign rsp_pc    = rsp_pc_q;
  assign rsp_fault = rsp_fault_q;

endmodule
